// File: rtl/basic_gates_pkg.sv
// Shared constants for the basic_gates block: gate indices, code count,
// and the four-row reference truth table indexed by the {a,b} code.
package basic_gates_pkg;

  localparam int NUM_GATES = 7;
  localparam int NUM_CODES = 4;

  localparam int GATE_NOT  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_OR   = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  // Bit g of each entry is the output of gate g for that {a,b} code.
  localparam logic [NUM_GATES-1:0] TRUTH_TABLE [NUM_CODES] = '{
    7'b1010101,  // {a,b}=00
    7'b0101101,  // {a,b}=01
    7'b0101100,  // {a,b}=10
    7'b1001010   // {a,b}=11
  };

  // Input combination code as used to index the seen bits and TRUTH_TABLE.
  function automatic logic [1:0] code_of(input logic a, input logic b);
    return {a, b};
  endfunction

endpackage

// File: rtl/basic_gates_if.sv
// Operand and result bundle of the gate bank. The master side drives the
// operands and observes the results; the slave side is the gate bank.
interface basic_gates_if;
  logic in_a;
  logic in_b;
  logic not_gate_out;
  logic and_gate_out;
  logic nand_gate_out;
  logic or_gate_out;
  logic nor_gate_out;
  logic xor_gate_out;
  logic xnor_gate_out;
  logic cov_done;

  modport master (
    output in_a, in_b,
    input  not_gate_out, and_gate_out, nand_gate_out, or_gate_out,
    input  nor_gate_out, xor_gate_out, xnor_gate_out, cov_done
  );

  modport slave (
    input  in_a, in_b,
    output not_gate_out, and_gate_out, nand_gate_out, or_gate_out,
    output nor_gate_out, xor_gate_out, xnor_gate_out, cov_done
  );
endinterface

// File: rtl/basic_gate_fn.sv
// Pure combinational gate function: two operands in, one bit per gate out.
// Plain operators are used so X/Z follow normal 4-state semantics.
module basic_gate_fn
  import basic_gates_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] y
);

  assign y[GATE_NOT]  = ~a;
  assign y[GATE_AND]  = a & b;
  assign y[GATE_NAND] = ~(a & b);
  assign y[GATE_OR]   = a | b;
  assign y[GATE_NOR]  = ~(a | b);
  assign y[GATE_XOR]  = a ^ b;
  assign y[GATE_XNOR] = ~(a ^ b);

endmodule

// File: rtl/basic_gates.sv
// Two-input logic gate bank with optional output register and a sticky
// flag that rises once every {in_a,in_b} combination has been sampled.
module basic_gates
  import basic_gates_pkg::*;
#(
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  basic_gates_if.slave  bus
);

  logic [NUM_GATES-1:0] fn_out;
  logic [NUM_GATES-1:0] gate_val;
  logic [1:0]           code;
  logic [NUM_CODES-1:0] seen_reg;
  logic [NUM_CODES-1:0] seen_next;
  logic                 cov_reg;

  basic_gate_fn u_fn (
    .a (bus.in_a),
    .b (bus.in_b),
    .y (fn_out)
  );

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [NUM_GATES-1:0] gate_reg;

      // Output flops; reset forces all gates low, including the inverting ones.
      always_ff @(posedge clk) begin
        if (!rst_n) gate_reg <= '0;
        else        gate_reg <= fn_out;
      end

      assign gate_val = gate_reg;
    end else begin : g_comb
      assign gate_val = fn_out;
    end
  endgenerate

  assign code = code_of(bus.in_a, bus.in_b);

  // Mark the code present at this edge; an unknown code matches nothing.
  always_comb begin
    seen_next = seen_reg;
    for (int i = 0; i < NUM_CODES; i++) begin
      if (code == 2'(i)) seen_next[i] = 1'b1;
    end
  end

  // Sticky seen bits and the registered all-seen flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_reg <= '0;
      cov_reg  <= 1'b0;
    end else begin
      seen_reg <= seen_next;
      cov_reg  <= &seen_reg;
    end
  end

  assign bus.not_gate_out  = gate_val[GATE_NOT];
  assign bus.and_gate_out  = gate_val[GATE_AND];
  assign bus.nand_gate_out = gate_val[GATE_NAND];
  assign bus.or_gate_out   = gate_val[GATE_OR];
  assign bus.nor_gate_out  = gate_val[GATE_NOR];
  assign bus.xor_gate_out  = gate_val[GATE_XOR];
  assign bus.xnor_gate_out = gate_val[GATE_XNOR];
  assign bus.cov_done      = cov_reg;

endmodule

// File: tb/tb_basic_gates.sv
// Bench for basic_gates: one combinational and one registered instance fed
// the same operands, checked against truth-table vectors, hand sequences and
// a randomized run scored by an arithmetic reference model.
module tb_basic_gates;
  import basic_gates_pkg::*;

  logic clk;
  logic rst_n;
  logic a;
  logic b;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [6:0] m_reg;
  bit   [3:0] m_seen;
  bit         m_cov;

  basic_gates_if if0 ();
  basic_gates_if if1 ();

  assign if0.in_a = a;
  assign if0.in_b = b;
  assign if1.in_a = a;
  assign if1.in_b = b;

  basic_gates #(.OUT_REG(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  basic_gates #(.OUT_REG(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic [6:0] exp;
  } vec_t;

  // Gate results derived with integer arithmetic from the operand values.
  function automatic logic [6:0] ref_gates(input bit ia, input bit ib);
    int s, p;
    logic [6:0] r;
    s = int'(ia) + int'(ib);
    p = int'(ia) * int'(ib);
    r[GATE_NOT]  = (ia == 1'b0);
    r[GATE_AND]  = (p == 1);
    r[GATE_NAND] = (p == 0);
    r[GATE_OR]   = (s > 0);
    r[GATE_NOR]  = (s == 0);
    r[GATE_XOR]  = (s % 2 == 1);
    r[GATE_XNOR] = (s % 2 == 0);
    return r;
  endfunction

  function automatic logic [6:0] outs0();
    return {if0.xnor_gate_out, if0.xor_gate_out, if0.nor_gate_out, if0.or_gate_out,
            if0.nand_gate_out, if0.and_gate_out, if0.not_gate_out};
  endfunction

  function automatic logic [6:0] outs1();
    return {if1.xnor_gate_out, if1.xor_gate_out, if1.nor_gate_out, if1.or_gate_out,
            if1.nand_gate_out, if1.and_gate_out, if1.not_gate_out};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s a=%b b=%b rst_n=%b got=%b want=%b", name, a, b, rst_n, act, exp);
    end else begin
      $display("ok   %s a=%b b=%b rst_n=%b got=%b", name, a, b, rst_n, act);
    end
  endtask

  // Advance one rising edge, update the model from what was sampled, then
  // let the DUT settle before any comparison.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_reg  = '0;
      m_seen = '0;
      m_cov  = 1'b0;
    end else begin
      m_cov  = (m_seen == 4'hF);
      m_seen[{a, b}] = 1'b1;
      m_reg  = ref_gates(a, b);
    end
    #1;
  endtask

  task automatic chk_cov(input string name, input bit exp);
    chk({name, "_u0"}, {6'd0, if0.cov_done}, {6'd0, exp});
    chk({name, "_u1"}, {6'd0, if1.cov_done}, {6'd0, exp});
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{a: 1'b0, b: 1'b0, exp: 7'b1010101};
    vecs[1] = '{a: 1'b1, b: 1'b0, exp: 7'b0101100};
    vecs[2] = '{a: 1'b0, b: 1'b1, exp: 7'b0101101};
    vecs[3] = '{a: 1'b1, b: 1'b1, exp: 7'b1001010};

    a = 1'b0; b = 1'b0; rst_n = 1'b0;
    m_reg = '0; m_seen = '0; m_cov = 1'b0;
    tick();
    tick();
    chk("reset_reg_outs", outs1(), 7'b0);
    chk_cov("reset_cov", 1'b0);

    // Truth table, comb instance under both reset levels; registered one follows.
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 2; r++) begin
        rst_n = r[0];
        a = vecs[i].a;
        b = vecs[i].b;
        tick();
        chk("tt_comb", outs0(), vecs[i].exp);
        chk("tt_reg", outs1(), r[0] ? vecs[i].exp : 7'b0);
        chk("tt_pkg", TRUTH_TABLE[{vecs[i].a, vecs[i].b}], vecs[i].exp);
      end
    end

    // Registered: reset wins over input 11, then one-edge latency after release.
    rst_n = 1'b0; a = 1'b1; b = 1'b1;
    tick();
    chk("reg_rst_11", outs1(), 7'b0);
    rst_n = 1'b1;
    tick();
    chk("reg_rel_11", outs1(), 7'b1001010);
    a = 1'b0; b = 1'b0;
    #1;
    chk("reg_latency_hold", outs1(), 7'b1001010);
    tick();
    chk("reg_latency_new", outs1(), 7'b1010101);

    // Coverage build-up.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    a = 0; b = 0; tick();
    a = 1; b = 0; tick();
    a = 0; b = 1; tick();
    chk_cov("cov_three", 1'b0);
    a = 1; b = 1; tick();
    chk_cov("cov_fourth_edge", 1'b0);
    tick();
    chk_cov("cov_set", 1'b1);
    a = 0; b = 0; tick();
    chk_cov("cov_sticky", 1'b1);

    // Reset mid-run then only two codes.
    rst_n = 1'b0; tick();
    chk_cov("cov_rst", 1'b0);
    rst_n = 1'b1;
    a = 0; b = 0; tick();
    a = 1; b = 1; tick(); tick();
    chk_cov("cov_two_codes", 1'b0);

    // Glitch on in_a between edges must not count code 10.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    a = 0; b = 0; tick();
    a = 1; #2; a = 0;
    tick();
    a = 0; b = 1; tick();
    a = 1; b = 1; tick(); tick();
    chk_cov("cov_glitch", 1'b0);
    a = 1; b = 0; tick(); tick();
    chk_cov("cov_after_glitch_real", 1'b1);

    // Randomized run against the reference model.
    rst_n = 1'b0; tick();
    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 15) != 0);
      a = 1'($urandom);
      b = 1'($urandom);
      #1;
      chk("rnd_comb", outs0(), ref_gates(a, b));
      tick();
      chk("rnd_reg", outs1(), m_reg);
      chk_cov("rnd_cov", m_cov);
    end

    // Unknown operand: AND with 0 and NAND with 0 stay resolved.
    a = 1'bx; b = 1'b0;
    #1;
    chk("x_and", {6'd0, if0.and_gate_out}, 7'd0);
    chk("x_nand", {6'd0, if0.nand_gate_out}, 7'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
